// File: rtl/correlator_pkt_reader.sv
// Reassembles the 5-byte correlator packet stream into a parallel record with
// valid/ready output, window-continuity tracking and stalled-packet timeout.
module correlator_pkt_reader #(
    parameter int TIMEOUT_EXP = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cg,
    input  logic       i_flush,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_winNum,
    output logic [7:0] o_countX,
    output logic [7:0] o_countY,
    output logic [7:0] o_countIsect,
    output logic [7:0] o_countSymdiff,
    output logic [7:0] o_gap,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [15:0] o_nDropped,
    output logic [7:0] o_nTimeouts
);

    localparam logic [TIMEOUT_EXP-1:0] IDLE_MAX = '1;

    logic [2:0]             idx;
    logic [3:0][7:0]        shadow;
    logic [TIMEOUT_EXP-1:0] idle;
    logic                   seen;
    logic [7:0]             expected;

    logic        accept;
    logic        timeout;
    logic        last;
    logic [7:0]  gap_c;
    logic [16:0] drop_sum;

    // Only byte 4 can be held off, and only by a full, unaccepted output slot.
    assign o_ready  = i_cg && !i_flush && (idx != 3'd4 || !o_valid || i_ready);
    assign accept   = i_valid && o_ready;
    assign timeout  = i_cg && (idx != 3'd0) && (idle == IDLE_MAX);
    // A byte arriving with the timeout restarts the packet, so it is never byte 4.
    assign last     = accept && (idx == 3'd4) && !timeout;
    assign gap_c    = seen ? (shadow[0] - expected) : 8'd0;
    assign drop_sum = {1'b0, o_nDropped} + {9'd0, gap_c};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx            <= 3'd0;
            shadow         <= '0;
            idle           <= '0;
            seen           <= 1'b0;
            expected       <= 8'd0;
            o_winNum       <= 8'd0;
            o_countX       <= 8'd0;
            o_countY       <= 8'd0;
            o_countIsect   <= 8'd0;
            o_countSymdiff <= 8'd0;
            o_gap          <= 8'd0;
            o_valid        <= 1'b0;
            o_nDropped     <= 16'd0;
            o_nTimeouts    <= 8'd0;
        end else if (i_cg) begin
            if (i_flush) begin
                idx     <= 3'd0;
                idle    <= '0;
                o_valid <= 1'b0;
                seen    <= 1'b0;
            end else begin
                if (timeout) begin
                    idle <= '0;
                    if (o_nTimeouts != 8'hFF)
                        o_nTimeouts <= o_nTimeouts + 8'd1;
                    if (accept) begin
                        shadow[0] <= i_data;
                        idx       <= 3'd1;
                    end else begin
                        idx <= 3'd0;
                    end
                end else if (accept) begin
                    idle <= '0;
                    if (idx == 3'd4) begin
                        idx <= 3'd0;
                    end else begin
                        shadow[idx[1:0]] <= i_data;
                        idx              <= idx + 3'd1;
                    end
                end else if (idx != 3'd0) begin
                    idle <= idle + 1'b1;
                end

                if (last) begin
                    o_winNum       <= shadow[0];
                    o_countX       <= shadow[1];
                    o_countY       <= shadow[2];
                    o_countIsect   <= shadow[3];
                    o_countSymdiff <= i_data;
                    o_gap          <= gap_c;
                    o_valid        <= 1'b1;
                    expected       <= shadow[0] + 8'd1;
                    seen           <= 1'b1;
                    o_nDropped     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                end else if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_correlator_pkt_reader.sv
// Directed bench: stimulus pushes expected records, a forked monitor pops and
// compares each record the consumer accepts.
module tb_correlator_pkt_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cg = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        valid = 1'b0;
    logic        ready_out;
    logic [7:0]  win, cx, cy, cis, csd, gap;
    logic        rec_valid;
    logic        cons_ready = 1'b1;
    logic [15:0] n_dropped;
    logic [7:0]  n_timeouts;

    correlator_pkt_reader #(.TIMEOUT_EXP(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_flush(flush),
        .i_data(data), .i_valid(valid), .o_ready(ready_out),
        .o_winNum(win), .o_countX(cx), .o_countY(cy),
        .o_countIsect(cis), .o_countSymdiff(csd), .o_gap(gap),
        .o_valid(rec_valid), .i_ready(cons_ready),
        .o_nDropped(n_dropped), .o_nTimeouts(n_timeouts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] w, x, y, is, sd, g;
    } rec_t;

    rec_t sb[$];
    int   rec_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_push = 0;
    int   n_rec = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        rec_t e, a;
        forever begin
            @(negedge clk);
            if (!rst && cg && !flush && rec_valid && cons_ready) begin
                n_rec++;
                rec_cyc.push_back(cyc);
                a = '{win, cx, cy, cis, csd, gap};
                if (sb.size() == 0) begin
                    check("unexpected_record", {16'd0, a}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("record", {16'd0, a}, {16'd0, e});
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        valid = 1'b1;
        data  = b;
        forever begin
            @(negedge clk);
            if (ready_out) break;
            n++;
            if (n > 50) begin
                check("byte_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic push_rec(input logic [7:0] w, input logic [7:0] g);
        sb.push_back('{w, w ^ 8'h11, w ^ 8'h22, w ^ 8'h33, w ^ 8'h44, g});
        n_push++;
    endtask

    task automatic send_pkt(input logic [7:0] w);
        send_byte(w);
        send_byte(w ^ 8'h11);
        send_byte(w ^ 8'h22);
        send_byte(w ^ 8'h33);
        send_byte(w ^ 8'h44);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        fork
            monitor_loop();
        join_none

        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {63'd0, rec_valid}, 64'd0);
        check("rst_ready", {63'd0, ready_out}, 64'd1);
        check("rst_fields", {16'd0, win, cx, cy, cis, csd, gap}, 64'd0);
        check("rst_counters", {40'd0, n_dropped, n_timeouts}, 64'd0);
        @(posedge clk); #1;

        // Back-to-back stream, consumer always ready
        push_rec(8'h10, 8'd0); push_rec(8'h11, 8'd0); push_rec(8'h12, 8'd0);
        t0 = cyc;
        send_pkt(8'h10); send_pkt(8'h11); send_pkt(8'h12);
        check("stream_no_stall", 64'(cyc - t0), 64'd15);
        step(2);
        check("stream_spacing1", 64'(rec_cyc[1] - rec_cyc[0]), 64'd5);
        check("stream_spacing2", 64'(rec_cyc[2] - rec_cyc[1]), 64'd5);
        check("stream_dropped", {48'd0, n_dropped}, 64'd0);

        // Drop and wrap from a fresh sequence
        flush = 1'b1; step(1); flush = 1'b0;
        push_rec(8'hFE, 8'd0); push_rec(8'h01, 8'd2); push_rec(8'h02, 8'd0);
        send_pkt(8'hFE); send_pkt(8'h01); send_pkt(8'h02);
        step(2);
        check("wrap_dropped", {48'd0, n_dropped}, 64'd2);

        // Back-pressure: slot full, next packet bytes 0-3 flow, byte 4 waits
        cons_ready = 1'b0;
        push_rec(8'h03, 8'd0); push_rec(8'h04, 8'd0);
        send_pkt(8'h03);
        t0 = cyc;
        send_byte(8'h04); send_byte(8'h04 ^ 8'h11);
        send_byte(8'h04 ^ 8'h22); send_byte(8'h04 ^ 8'h33);
        check("bp_bytes0to3", 64'(cyc - t0), 64'd4);
        valid = 1'b1;
        data  = 8'h04 ^ 8'h44;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", {63'd0, ready_out}, 64'd0);
            check("bp_hold", {47'd0, rec_valid, win, csd}, {47'd0, 1'b1, 8'h03, 8'h03 ^ 8'h44});
        end
        @(posedge clk); #1;
        cons_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_rise", {63'd0, ready_out}, 64'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        step(2);

        // Timeout: 2 bytes, 7 idle cycles, then a full packet
        send_byte(8'hAA); send_byte(8'hBB);
        step(7);
        push_rec(8'h05, 8'd0);
        send_pkt(8'h05);
        step(2);
        check("timeout_count", {56'd0, n_timeouts}, 64'd1);

        // Flush mid-packet
        send_byte(8'h77); send_byte(8'h66); send_byte(8'h55);
        flush = 1'b1; step(1); flush = 1'b0;
        check("flush_valid", {63'd0, rec_valid}, 64'd0);
        push_rec(8'h40, 8'd0); push_rec(8'h41, 8'd0);
        send_pkt(8'h40); send_pkt(8'h41);
        step(2);
        check("flush_dropped", {48'd0, n_dropped}, 64'd2);

        // Gating mid-packet must not time out
        push_rec(8'h42, 8'd0);
        send_byte(8'h42); send_byte(8'h42 ^ 8'h11);
        cg = 1'b0;
        @(negedge clk);
        check("gate_ready", {63'd0, ready_out}, 64'd0);
        step(20);
        cg = 1'b1;
        check("gate_no_timeout", {56'd0, n_timeouts}, 64'd1);
        send_byte(8'h42 ^ 8'h22); send_byte(8'h42 ^ 8'h33); send_byte(8'h42 ^ 8'h44);
        step(2);

        // Reset mid-packet with the output slot valid
        cons_ready = 1'b0;
        send_pkt(8'h43);
        @(negedge clk);
        check("slot_full_before_rst", {63'd0, rec_valid}, 64'd1);
        @(posedge clk); #1;
        send_byte(8'h50); send_byte(8'h51);
        rst = 1'b1; step(1); rst = 1'b0;
        @(negedge clk);
        check("rst2_valid", {63'd0, rec_valid}, 64'd0);
        check("rst2_fields", {16'd0, win, cx, cy, cis, csd, gap}, 64'd0);
        check("rst2_counters", {40'd0, n_dropped, n_timeouts}, 64'd0);
        check("rst2_ready", {63'd0, ready_out}, 64'd1);
        @(posedge clk); #1;
        cons_ready = 1'b1;
        push_rec(8'h99, 8'd0);
        send_pkt(8'h99);
        step(3);
        check("post_rst_dropped", {48'd0, n_dropped}, 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("rec_count", 64'(n_rec), 64'(n_push));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
